key_event_unit: RTL and testbench
=================================

// Module: key_event_unit
// PURPOSE
//  Parametrised N-key input conditioner: synchronises raw push buttons, debounces each key,
//  and emits one-cycle press/release pulses, a stable key-level vector (keycode form) and a
//  running press counter. Sits between board KEY pins and GameController/address logic,
//  replacing ad-hoc per-design Wait/PressKey/KeyRelease FSMs.
// PARAMETERS
//  NUM_KEYS        4        number of independent key channels (1..8)
//  DEBOUNCE_CYCLES 500000   consecutive stable samples to accept a change (>=1; 10 ms @ 50 MHz)
//  ACTIVE_LOW      1        1: raw key_in low = pressed; 0: high = pressed
//  REPEAT_DELAY    25000000 cycles from first press pulse to first repeat (>=1)
//  REPEAT_PERIOD   5000000  cycles between subsequent repeats (>=1)
// PORTS
//  Clk            in   1         system clock (CLOCK_50)
//  Reset          in   1         synchronous, active-high reset
//  key_in         in   NUM_KEYS  raw asynchronous key pins
//  key_level      out  NUM_KEYS  debounced state, 1 = pressed
//  keycode        out  8         {zero pad, key_level}
//  press_pulse    out  NUM_KEYS  1-cycle pulse per accepted press (and repeat, if enabled)
//  release_pulse  out  NUM_KEYS  1-cycle pulse per accepted release
//  repeat_pulse   out  NUM_KEYS  1-cycle pulse marking auto-repeat presses
//  any_press      out  1         OR of press_pulse
//  press_count    out  16        total press_pulse events since reset
// BEHAVIOUR
//  - Input: 2-flop synchroniser per key, polarity normalised to pressed=1; flops reset to 0.
//  - Per-key FSM, one counter each, cleared on every state change:
//    WAIT: synced=1 -> PRESS_CHK.
//    PRESS_CHK: synced=0 -> WAIT (glitch, no pulse); synced=1 and cnt==DEBOUNCE_CYCLES-1
//      -> HELD, press_pulse=1 next cycle; else cnt++.
//    HELD: synced=0 -> RELEASE_CHK.
//    RELEASE_CHK: synced=1 -> HELD (no pulse); synced=0 and cnt==DEBOUNCE_CYCLES-1
//      -> WAIT, release_pulse=1 next cycle; else cnt++.
//  - Latency: raw change first sampled at edge 0 and held stable -> pulse high between
//    edges D+2 and D+3 (D=DEBOUNCE_CYCLES). key_level rises/falls same cycle as its pulse.
//  - key_level=1 in HELD and RELEASE_CHK; all outputs registered.
//  - press_count adds popcount(press_pulse) each cycle; simultaneous keys all counted;
//    modulo 2^16 (16'hFFFF + 1 -> 16'h0000).
//  - Reset (any state): all FSMs WAIT, counters 0, every output 0 next cycle. A key held
//    through reset is re-debounced: press_pulse D+2 edges after the first post-reset edge.
//  - Keys fully independent; no priority, no interlock.
// CONFIGURATION
//  KEY_AUTOREPEAT_EN defined: in HELD a repeat counter runs from the press pulse; at
//    REPEAT_DELAY cycles, then every REPEAT_PERIOD, press_pulse and repeat_pulse assert
//    together for 1 cycle (counted in press_count). Leaving HELD cancels repeat; a
//    RELEASE_CHK bounce back to HELD restarts from REPEAT_DELAY.
//  Undefined: no repeat logic synthesised; repeat_pulse tied 0; one press_pulse per press.
// TESTING (bench params: NUM_KEYS=4, D=4, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1 key_in=4'b1110 from edge 0, held 20 cycles -> press_pulse=4'b0001 only between edges 6-7,
//    key_level=4'b0001, keycode=8'h01, any_press=1 that cycle, press_count=1.
//  2 key_in[1] low 3 cycles then high -> no pulses, key_level=0, press_count unchanged.
//  3 from scenario 1 raise key_in[0] at edge 30 -> release_pulse=4'b0001 edges 36-37, then
//    key_level=0; a 2-cycle high bounce during HELD -> no release_pulse.
//  4 keys 0 and 2 pressed same edge -> press_pulse=4'b0101 same cycle, keycode=8'h05,
//    press_count +2; 65536 total presses -> press_count wraps to 0.
//  5 Reset high 1 cycle while key0 HELD and still pressed -> all outputs 0 next cycle;
//    press_pulse[0] again 6 edges after Reset deasserts.
//  6 KEY_AUTOREPEAT_EN, key0 held 30 cycles -> repeat_pulse/press_pulse at press+10,+13,+16..;
//    without macro -> single press_pulse, repeat_pulse always 0.

Source files
------------

// File: rtl/key_event_unit.sv
// key_event_unit: N-key push-button conditioner.
// Each key is synchronised, polarity-normalised to pressed=1 and debounced by
// its own four-state FSM. The unit produces registered one-cycle press/release
// pulses, a stable level vector, an 8-bit keycode and a 16-bit press counter.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat while a key is held).
module key_event_unit #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [7:0]          keycode,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse,
    output logic                any_press,
    output logic [15:0]         press_count
);

    typedef enum logic [1:0] {
        WAIT        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_t;

    // The per-key counter is shared: it debounces in the CHK states and
    // times auto-repeat in HELD, so it must cover the largest interval.
`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_MAX = (RPT_MAX > DEBOUNCE_CYCLES) ? RPT_MAX : DEBOUNCE_CYCLES;
`else
    // Repeat timing does not exist here; the zero-weighted term only keeps
    // the repeat parameters referenced.
    localparam int CNT_MAX = DEBOUNCE_CYCLES + 0 * (REPEAT_DELAY + REPEAT_PERIOD);
`endif
    localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    logic [NUM_KEYS-1:0] meta;
    logic [NUM_KEYS-1:0] synced;
    key_state_t          state      [NUM_KEYS];
    key_state_t          state_next [NUM_KEYS];
    logic [CNT_W-1:0]    cnt        [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_next   [NUM_KEYS];
    logic [NUM_KEYS-1:0] press_next;
    logic [NUM_KEYS-1:0] release_next;
    logic [NUM_KEYS-1:0] level_next;
    logic [3:0]          press_add;
`ifdef KEY_AUTOREPEAT_EN
    logic [NUM_KEYS-1:0] repeat_next;
    logic [NUM_KEYS-1:0] first_q;     // 1 until the first repeat after entering HELD
    logic [NUM_KEYS-1:0] first_next;
`endif

    // Two-flop synchroniser with polarity normalised to pressed=1.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (Reset) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= (ACTIVE_LOW != 0) ? ~key_in : key_in;
            synced <= meta;
        end
    end

    // Per-key state and counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: these arrays are control state, not storage, so every entry is reset.
            for (int k = 0; k < NUM_KEYS; k++) begin
                state[k] <= WAIT;
                cnt[k]   <= '0;
            end
`ifdef KEY_AUTOREPEAT_EN
            first_q <= '0;
`endif
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state[k] <= state_next[k];
                cnt[k]   <= cnt_next[k];
            end
`ifdef KEY_AUTOREPEAT_EN
            first_q <= first_next;
`endif
        end
    end

    // Next-state, counter and pulse decode for every key.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        press_add = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_next[k]   = state[k];
            cnt_next[k]     = '0;
            press_next[k]   = 1'b0;
            release_next[k] = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            repeat_next[k]  = 1'b0;
            first_next[k]   = first_q[k];
`endif
            unique case (state[k])
                WAIT: begin
                    if (synced[k]) state_next[k] = PRESS_CHK;
                end
                PRESS_CHK: begin
                    if (!synced[k]) begin
                        state_next[k] = WAIT;
                    end else if (cnt[k] == DB_LAST) begin
                        state_next[k] = HELD;
                        press_next[k] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        first_next[k] = 1'b1;
`endif
                    end else begin
                        cnt_next[k] = cnt[k] + 1'b1;
                    end
                end
                HELD: begin
                    if (!synced[k]) begin
                        state_next[k] = RELEASE_CHK;
`ifdef KEY_AUTOREPEAT_EN
                    end else if (cnt[k] == (first_q[k] ? RD_LAST : RP_LAST)) begin
                        press_next[k]  = 1'b1;
                        repeat_next[k] = 1'b1;
                        first_next[k]  = 1'b0;
                    end else begin
                        cnt_next[k] = cnt[k] + 1'b1;
`endif
                    end
                end
                RELEASE_CHK: begin
                    if (synced[k]) begin
                        state_next[k] = HELD;
`ifdef KEY_AUTOREPEAT_EN
                        first_next[k] = 1'b1;
`endif
                    end else if (cnt[k] == DB_LAST) begin
                        state_next[k]   = WAIT;
                        release_next[k] = 1'b1;
                    end else begin
                        cnt_next[k] = cnt[k] + 1'b1;
                    end
                end
                default: state_next[k] = WAIT;
            endcase
            level_next[k] = (state_next[k] == HELD) || (state_next[k] == RELEASE_CHK);
            press_add     = press_add + 4'(press_next[k]);
        end
    end

    // Registered outputs; the counter wraps naturally at 16 bits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_level     <= '0;
            keycode       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            any_press     <= 1'b0;
            press_count   <= '0;
`ifdef KEY_AUTOREPEAT_EN
            repeat_pulse  <= '0;
`endif
        end else begin
            key_level     <= level_next;
            keycode       <= 8'(level_next);
            press_pulse   <= press_next;
            release_pulse <= release_next;
            any_press     <= |press_next;
            press_count   <= press_count + 16'(press_add);
`ifdef KEY_AUTOREPEAT_EN
            repeat_pulse  <= repeat_next;
`endif
        end
    end

`ifndef KEY_AUTOREPEAT_EN
    assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_key_event_unit.sv
// Directed bench for key_event_unit: a 4-key active-low instance with
// DEBOUNCE_CYCLES=4 and an 8-key active-high instance with DEBOUNCE_CYCLES=1
// used to drive press_count through its 16-bit wrap quickly.
module tb_key_event_unit;

`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       Clk;
    logic       Reset;
    logic [3:0] key_in;
    logic [3:0] key_level, press_pulse, release_pulse, repeat_pulse;
    logic [7:0] keycode;
    logic       any_press;
    logic [15:0] press_count;

    logic [7:0] key_in_w;
    logic [7:0] key_level_w, press_pulse_w, release_pulse_w, repeat_pulse_w;
    logic [7:0] keycode_w;
    logic       any_press_w;
    logic [15:0] press_count_w;

    int vectors;
    int miscompares;

    key_event_unit #(
        .NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .Clk(Clk), .Reset(Reset), .key_in(key_in),
        .key_level(key_level), .keycode(keycode),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse), .any_press(any_press),
        .press_count(press_count)
    );

    key_event_unit #(
        .NUM_KEYS(8), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(0),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_w (
        .Clk(Clk), .Reset(Reset), .key_in(key_in_w),
        .key_level(key_level_w), .keycode(keycode_w),
        .press_pulse(press_pulse_w), .release_pulse(release_pulse_w),
        .repeat_pulse(repeat_pulse_w), .any_press(any_press_w),
        .press_count(press_count_w)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One press/release period on the wide instance: 2 cycles pressed, 2 released.
    task automatic period_w(input logic [7:0] keys);
        key_in_w = keys;
        tick();
        tick();
        key_in_w = '0;
        tick();
        tick();
    endtask

    initial begin
        logic [3:0] seen;
        vectors     = 0;
        miscompares = 0;

        // Reset with all keys released.
        Reset    = 1'b1;
        key_in   = 4'hF;
        key_in_w = 8'h00;
        repeat (3) tick();
        check("rst key_level", 32'(key_level), 0);
        check("rst keycode", 32'(keycode), 0);
        check("rst press_pulse", 32'(press_pulse), 0);
        check("rst release_pulse", 32'(release_pulse), 0);
        check("rst repeat_pulse", 32'(repeat_pulse), 0);
        check("rst any_press", 32'(any_press), 0);
        check("rst press_count", 32'(press_count), 0);
        Reset = 1'b0;

        // Key 0 pressed from edge 0: pulse between edges 6 and 7.
        key_in = 4'b1110;
        for (int e = 0; e <= 7; e++) begin
            tick();
            check("s1 press_pulse", 32'(press_pulse), (e == 6) ? 1 : 0);
            check("s1 key_level", 32'(key_level), (e >= 6) ? 1 : 0);
            if (e == 6) begin
                check("s1 keycode", 32'(keycode), 32'h01);
                check("s1 any_press", 32'(any_press), 1);
                check("s1 press_count", 32'(press_count), 1);
            end
        end

        // Two-cycle release bounce while held: no release pulse.
        for (int e = 8; e <= 13; e++) begin
            key_in = (e == 8 || e == 9) ? 4'hF : 4'b1110;
            tick();
            check("bounce release_pulse", 32'(release_pulse), 0);
            check("bounce key_level", 32'(key_level), 1);
        end

        // Real release first sampled at edge 14: pulse at edge 20.
        for (int e = 14; e <= 21; e++) begin
            key_in = 4'hF;
            tick();
            check("s3 release_pulse", 32'(release_pulse), (e == 20) ? 1 : 0);
            check("s3 key_level", 32'(key_level), (e < 20) ? 1 : 0);
        end
        check("s3 press_count", 32'(press_count), 1);

        // Three-cycle glitch on key 1: nothing accepted.
        seen   = '0;
        key_in = 4'b1101;
        repeat (3) begin
            tick();
            seen = seen | press_pulse | release_pulse;
        end
        key_in = 4'hF;
        repeat (10) begin
            tick();
            seen = seen | press_pulse | release_pulse;
        end
        check("s2 glitch pulses", 32'(seen), 0);
        check("s2 key_level", 32'(key_level), 0);
        check("s2 press_count", 32'(press_count), 1);

        // Keys 0 and 2 pressed together.
        key_in = 4'b1010;
        for (int e = 0; e <= 7; e++) begin
            tick();
            check("s4 press_pulse", 32'(press_pulse), (e == 6) ? 32'h5 : 0);
            if (e == 6) begin
                check("s4 keycode", 32'(keycode), 32'h05);
                check("s4 any_press", 32'(any_press), 1);
                check("s4 press_count", 32'(press_count), 3);
            end
        end
        key_in = 4'hF;
        for (int e = 8; e <= 15; e++) begin
            tick();
            check("s4 release_pulse", 32'(release_pulse), (e == 14) ? 32'h5 : 0);
        end
        check("s4 key_level", 32'(key_level), 0);

        // Reset while key 0 is held, then re-debounce after reset.
        key_in = 4'b1110;
        repeat (7) tick();
        check("s5 pre press_pulse", 32'(press_pulse), 1);
        check("s5 pre press_count", 32'(press_count), 4);
        Reset = 1'b1;
        tick();
        check("s5 rst key_level", 32'(key_level), 0);
        check("s5 rst keycode", 32'(keycode), 0);
        check("s5 rst press_pulse", 32'(press_pulse), 0);
        check("s5 rst any_press", 32'(any_press), 0);
        check("s5 rst press_count", 32'(press_count), 0);
        Reset = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            tick();
            check("s5 press_pulse", 32'(press_pulse), (e == 6) ? 1 : 0);
            if (e == 6) begin
                check("s5 press_count", 32'(press_count), 1);
                check("s5 key_level", 32'(key_level), 1);
            end
        end
        key_in = 4'hF;
        repeat (8) tick();
        check("s5 released", 32'(key_level), 0);

        // Long hold: repeats at press+10, +13, ... only with auto-repeat.
        key_in = 4'b1110;
        for (int e = 0; e <= 39; e++) begin
            logic rep_exp;
            if (e == 30) key_in = 4'hF;
            tick();
            rep_exp = AR && (e >= 16) && (e <= 31) && ((e - 16) % 3 == 0);
            check("s6 repeat_pulse", 32'(repeat_pulse), rep_exp ? 1 : 0);
            check("s6 press_pulse", 32'(press_pulse), ((e == 6) || rep_exp) ? 1 : 0);
            check("s6 release_pulse", 32'(release_pulse), (e == 36) ? 1 : 0);
        end
        check("s6 press_count", 32'(press_count), AR ? 8 : 2);

        // Wide instance: 8 simultaneous presses per period, then the 16-bit wrap.
        period_w(8'hFF);
        check("wrap first press_pulse", 32'(press_pulse_w), 32'hFF);
        check("wrap first press_count", 32'(press_count_w), 8);
        check("wrap first keycode", 32'(keycode_w), 32'hFF);
        for (int p = 1; p < 8191; p++) period_w(8'hFF);
        check("wrap count FFF8", 32'(press_count_w), 32'hFFF8);
        for (int p = 0; p < 7; p++) period_w(8'h01);
        check("wrap count FFFF", 32'(press_count_w), 32'hFFFF);
        period_w(8'h01);
        check("wrap count 0000", 32'(press_count_w), 0);
        repeat (4) tick();
        check("wrap settled level", 32'(key_level_w), 0);
        check("wrap settled count", 32'(press_count_w), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
